// File: rtl/segn_scan.sv
// segn_scan: multiplexed N-digit seven-segment scan driver with dead-time blanking
// and tear-free frame-synchronous updates. Define SEG_PWM_EN to add `bright` PWM dimming.
module segn_scan #(
    parameter int DIGITS = 8,
    parameter int DIV    = 10000,
    parameter int DEAD   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
`ifdef SEG_PWM_EN
    input  logic [3:0]            bright,
`endif
    output logic                  busy,
    output logic                  frame_start,
    output logic [DIGITS-1:0]     seg_sel_n,
    output logic [7:0]            seg
);

    localparam int TW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [7:0] c;
        case (nib)
            4'h0: c = 8'hC0;
            4'h1: c = 8'hF9;
            4'h2: c = 8'hA4;
            4'h3: c = 8'hB0;
            4'h4: c = 8'h99;
            4'h5: c = 8'h92;
            4'h6: c = 8'h82;
            4'h7: c = 8'hF8;
            4'h8: c = 8'h80;
            4'h9: c = 8'h90;
            4'hA: c = 8'h88;
            4'hB: c = 8'h83;
            4'hC: c = 8'hC6;
            4'hD: c = 8'hA1;
            4'hE: c = 8'h86;
            default: c = 8'h8E;
        endcase
        return c[6:0];
    endfunction

    logic [TW-1:0]         tick_p0;
    logic [IW-1:0]         idx_p0;
    logic                  frame_end_p0;
    logic                  in_dead_p0;
    logic                  pwm_on_p0;
    logic                  lit_p0;
    logic [3:0]            nib_p0;
    logic [DIGITS-1:0]     sel_one_p0;
    logic [DIGITS-1:0]     sel_n_p0;
    logic [7:0]            seg_p0;
    logic                  fs_p0;

    logic                  pending;
    logic [4*DIGITS-1:0]   sh_data, st_data;
    logic [DIGITS-1:0]     sh_dp,   st_dp;
    logic [DIGITS-1:0]     sh_en,   st_en;

    // Stage p0: slot counters
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_p0 <= '0;
            idx_p0  <= '0;
        end else if (tick_p0 == TICK_LAST) begin
            tick_p0 <= '0;
            idx_p0  <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IW'(1);
        end else begin
            tick_p0 <= tick_p0 + TW'(1);
        end
    end

    assign frame_end_p0 = (tick_p0 == TICK_LAST) && (idx_p0 == IDX_LAST);

    // A load landing on the boundary goes straight to the shadow so it is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            st_data <= '0;
            st_dp   <= '0;
            st_en   <= '0;
            sh_data <= '0;
            sh_dp   <= '0;
            sh_en   <= '0;
        end else begin
            if (load) begin
                st_data <= data;
                st_dp   <= dp;
                st_en   <= digit_en;
            end
            if (frame_end_p0 && load) begin
                sh_data <= data;
                sh_dp   <= dp;
                sh_en   <= digit_en;
                pending <= 1'b0;
            end else if (frame_end_p0 && pending) begin
                sh_data <= st_data;
                sh_dp   <= st_dp;
                sh_en   <= st_en;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    assign busy = pending;

`ifdef SEG_PWM_EN
    logic [3:0] pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= 4'd0;
        end else begin
            pwm <= pwm + 4'd1;
        end
    end

    assign pwm_on_p0 = (pwm <= bright);
`else
    assign pwm_on_p0 = 1'b1;
`endif

    generate
        if (DEAD > 0) begin : g_dead
            assign in_dead_p0 = (tick_p0 < TW'(DEAD));
        end else begin : g_nodead
            assign in_dead_p0 = 1'b0;
        end
    endgenerate

    always_comb begin
        nib_p0     = sh_data[{idx_p0, 2'b00} +: 4];
        lit_p0     = !in_dead_p0 && sh_en[idx_p0] && pwm_on_p0;
        sel_one_p0 = '0;
        sel_one_p0[idx_p0] = 1'b1;
        sel_n_p0   = '1;
        seg_p0     = 8'hFF;
        if (lit_p0) begin
            sel_n_p0 = ~sel_one_p0;
            seg_p0   = {~sh_dp[idx_p0], seg_code(nib_p0)};
        end
        fs_p0 = (tick_p0 == '0) && (idx_p0 == '0);
    end

    // Stage p1: registered pin drive, one cycle behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_sel_n   <= '1;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            seg_sel_n   <= sel_n_p0;
            seg         <= seg_p0;
            frame_start <= fs_p0;
        end
    end

endmodule

// File: tb/tb_segn_scan.sv
// Directed bench for segn_scan with DIGITS=4, DIV=8, DEAD=2 (32-cycle frame).
module tb_segn_scan;
    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int DEAD   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        load = 1'b0;
`ifdef SEG_PWM_EN
    logic [3:0]  bright = 4'hF;
`endif
    logic        busy;
    logic        frame_start;
    logic [3:0]  seg_sel_n;
    logic [7:0]  seg;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    segn_scan #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .dp          (dp),
        .digit_en    (digit_en),
        .load        (load),
`ifdef SEG_PWM_EN
        .bright      (bright),
`endif
        .busy        (busy),
        .frame_start (frame_start),
        .seg_sel_n   (seg_sel_n),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    // Output cycle c (1 = first after reset release) shows counter state c-1.
    function automatic logic [11:0] expect_out(input int c, input logic [3:0] en,
                                               input logic [31:0] segs, input int lim);
        int pos, t, d;
        pos = (c - 1) % 32;
        t   = pos % 8;
        d   = pos / 8;
        if (t >= DEAD && en[d] && ((c - 1) % 16) <= lim)
            return {~(4'b0001 << d), segs[d*8 +: 8]};
        return 12'hFFF;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_inputs();
        load = 1'b0;
        data = 16'h7777;
        dp = 4'h0;
        digit_en = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        tests++;
        if (seg_sel_n !== 4'hF) begin fails++; $display("FAIL reset_sel got=%h exp=f", seg_sel_n); end
        tests++;
        if (seg !== 8'hFF) begin fails++; $display("FAIL reset_seg got=%h exp=ff", seg); end
        tests++;
        if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_idle();
        do_reset();
        while (cyc < 64) begin
            step();
            tests++;
            if ({seg_sel_n, seg} !== 12'hFFF) begin
                fails++; $display("FAIL idle_out cyc=%0d got=%h exp=fff", cyc, {seg_sel_n, seg});
            end
            tests++;
            if (frame_start !== (((cyc - 1) % 32) == 0)) begin
                fails++; $display("FAIL idle_fs cyc=%0d got=%b", cyc, frame_start);
            end
        end
    endtask

    task automatic test_load();
        logic [11:0] e;
        do_reset();
        while (cyc < 64) begin
            step();
            if (cyc >= 4) begin
                tests++;
                if (busy !== (cyc <= 31)) begin
                    fails++; $display("FAIL load_busy cyc=%0d got=%b exp=%b", cyc, busy, cyc <= 31);
                end
            end
            e = (cyc <= 32) ? 12'hFFF : expect_out(cyc, 4'hF, 32'hB08812C0, 15);
            tests++;
            if ({seg_sel_n, seg} !== e) begin
                fails++; $display("FAIL load_out cyc=%0d got=%h exp=%h", cyc, {seg_sel_n, seg}, e);
            end
            tests++;
            if (frame_start !== (((cyc - 1) % 32) == 0)) begin
                fails++; $display("FAIL load_fs cyc=%0d got=%b", cyc, frame_start);
            end
            idle_inputs();
            if (cyc == 3) begin
                load = 1'b1; data = 16'h3A50; dp = 4'b0010; digit_en = 4'hF;
            end
        end
    endtask

    task automatic test_double_load();
        logic [11:0] e;
        do_reset();
        while (cyc < 64) begin
            step();
            tests++;
            if (busy !== (cyc >= 6 && cyc <= 31)) begin
                fails++; $display("FAIL dbl_busy cyc=%0d got=%b", cyc, busy);
            end
            e = (cyc <= 32) ? 12'hFFF : expect_out(cyc, 4'hF, 32'hA4A4A4A4, 15);
            tests++;
            if ({seg_sel_n, seg} !== e) begin
                fails++; $display("FAIL dbl_out cyc=%0d got=%h exp=%h", cyc, {seg_sel_n, seg}, e);
            end
            idle_inputs();
            if (cyc == 5) begin
                load = 1'b1; data = 16'h1111; digit_en = 4'hF;
            end else if (cyc == 12) begin
                load = 1'b1; data = 16'h2222; digit_en = 4'hF;
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [11:0] e;
        do_reset();
        while (cyc < 64) begin
            step();
            tests++;
            if (busy !== 1'b0) begin
                fails++; $display("FAIL bnd_busy cyc=%0d got=%b exp=0", cyc, busy);
            end
            e = (cyc <= 32) ? 12'hFFF : expect_out(cyc, 4'hF, 32'h0E86A1C6, 15);
            tests++;
            if ({seg_sel_n, seg} !== e) begin
                fails++; $display("FAIL bnd_out cyc=%0d got=%h exp=%h", cyc, {seg_sel_n, seg}, e);
            end
            idle_inputs();
            if (cyc == 31) begin
                load = 1'b1; data = 16'hFEDC; dp = 4'b1000; digit_en = 4'hF;
            end
        end
    endtask

    task automatic test_enable_mask();
        logic [11:0] e;
        logic [3:0]  low;
        int          last_d;
        int          gap;
        int          d;
        last_d = -1;
        gap = 0;
        do_reset();
        while (cyc < 96) begin
            step();
            e = (cyc <= 32) ? 12'hFFF : expect_out(cyc, 4'b0101, 32'h00300079, 15);
            tests++;
            if ({seg_sel_n, seg} !== e) begin
                fails++; $display("FAIL mask_out cyc=%0d got=%h exp=%h", cyc, {seg_sel_n, seg}, e);
            end
            low = ~seg_sel_n;
            tests++;
            if ($countones(low) > 1) begin
                fails++; $display("FAIL mask_onehot cyc=%0d got=%b exp=at-most-one-low", cyc, seg_sel_n);
            end
            if (low != 4'h0) begin
                d = 0;
                for (int i = 0; i < 4; i++) if (low[i]) d = i;
                if (last_d >= 0 && d != last_d) begin
                    tests++;
                    if (gap < DEAD) begin
                        fails++; $display("FAIL mask_gap cyc=%0d got=%0d exp>=%0d", cyc, gap, DEAD);
                    end
                end
                last_d = d;
                gap = 0;
            end else begin
                gap++;
            end
            idle_inputs();
            if (cyc == 1) begin
                load = 1'b1; data = 16'h4321; dp = 4'b0101; digit_en = 4'b0101;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        while (cyc < 44) begin
            step();
            if (cyc == 36) begin
                tests++;
                if ({seg_sel_n, seg} !== 12'hE80) begin
                    fails++; $display("FAIL rmid_lit got=%h exp=e80", {seg_sel_n, seg});
                end
            end
            if (cyc == 41) begin
                tests++;
                if (busy !== 1'b1) begin fails++; $display("FAIL rmid_pend got=%b exp=1", busy); end
            end
            idle_inputs();
            if (cyc == 2) begin
                load = 1'b1; data = 16'h8888; digit_en = 4'hF;
            end else if (cyc == 40) begin
                load = 1'b1; data = 16'h1234; digit_en = 4'hF;
            end
        end
        rst = 1'b1;
        step();
        tests++;
        if ({seg_sel_n, seg} !== 12'hFFF) begin
            fails++; $display("FAIL rmid_blank got=%h exp=fff", {seg_sel_n, seg});
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        step();
        rst = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            step();
            tests++;
            if ({seg_sel_n, seg, busy} !== 13'h1FFE) begin
                fails++; $display("FAIL rmid_discard cyc=%0d got=%h exp=1ffe", cyc, {seg_sel_n, seg, busy});
            end
        end
    endtask

`ifdef SEG_PWM_EN
    task automatic test_pwm();
        logic [11:0] e;
        bright = 4'd3;
        do_reset();
        while (cyc < 64) begin
            step();
            e = (cyc <= 32) ? 12'hFFF : expect_out(cyc, 4'hF, 32'h80808080, 3);
            tests++;
            if ({seg_sel_n, seg} !== e) begin
                fails++; $display("FAIL pwm_out cyc=%0d got=%h exp=%h", cyc, {seg_sel_n, seg}, e);
            end
            idle_inputs();
            if (cyc == 1) begin
                load = 1'b1; data = 16'h8888; digit_en = 4'hF;
            end
        end
        bright = 4'hF;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_load();
        test_double_load();
        test_boundary_load();
        test_enable_mask();
        test_reset_mid();
`ifdef SEG_PWM_EN
        test_pwm();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/segn_scan.md
# segn_scan

Parametrised multiplexed seven-segment scan driver for the board display path: N hex digits, per-digit decimal point and enable, anti-ghosting dead time, and tear-free frame-synchronous updates. It sits between the CPU debug/IO registers and the board `seg_sel_n`/`seg` pins. It supersedes the fixed 16-digit scanner.

## Interface
- `DIGITS`, default 8: number of digits, 1..16.
- `DIV`, default 10000: clk cycles per digit slot, 2..2^20.
- `DEAD`, default 16: blank cycles at the start of each slot, 0..DIV-1.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `data` in 4*DIGITS: hex nibbles; digit i = `data[4i+3:4i]`.
- `dp` in DIGITS: decimal point per digit, 1 = lit.
- `digit_en` in DIGITS: 1 = digit shown, 0 = digit slot blanked.
- `load` in 1: one-cycle strobe; captures `data`/`dp`/`digit_en` into staging.
- `bright` in 4: PWM duty. Only present with `SEG_PWM_EN`.
- `busy` out 1: staged update pending (not yet visible).
- `frame_start` out 1: one-cycle pulse, aligned with the first output cycle of digit 0.
- `seg_sel_n` out DIGITS: active-low digit select; bit i selects digit i.
- `seg` out 8: active-low segments; `seg[7]` is the dp, `seg[6:0]` are segments g..a.

## Operation
- Counters:
  - `tick` runs 0..DIV-1.
  - On `tick`==DIV-1, `tick` goes to 0 and `idx` increments.
  - `idx` wraps from DIGITS-1 to 0; non-power-of-2 DIGITS must wrap correctly.
  - A frame is DIGITS*DIV cycles.
- Registers:
  - Shadow set {data, dp, digit_en} drives the display.
  - Staging set is loaded by `load`.
- Update protocol:
  - `load`=1 → staging captures the inputs and `pending` is set.
  - At the frame boundary edge (`tick`==DIV-1 and `idx`==DIGITS-1) with `pending`=1: shadow ← staging, `pending` ← 0.
  - A second `load` while pending overwrites staging. Last write wins; only one transfer occurs.
  - `load` on the boundary cycle: inputs go into both staging and shadow, and `pending` stays 0.
- `busy` = `pending`.
- Digit drive for slot `idx`:
  - Blank when `tick` < DEAD, or `digit_en[idx]`=0, or (with `SEG_PWM_EN`) the PWM is off.
  - Blank means `seg_sel_n` all ones and `seg`=8'hFF.
  - Otherwise `seg_sel_n` = ~(1<<idx) and `seg` = {~dp[idx], code[6:0]}.
- `code` for nibble 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (hex; bit7 dropped).
- Reset values:
  - `tick`=0, `idx`=0, shadow=0, staging=0, `pending`=0.
  - `seg_sel_n` all ones, `seg`=8'hFF, `frame_start`=0, `busy`=0.
  - Reset in the middle of a pending update discards it.

## Timing
- `seg_sel_n`, `seg` and `frame_start` are registered and lag counter state by one cycle.
- After reset deasserts at edge E0, the first lit output for digit 0 appears at edge E0+DEAD+1. This holds with `digit_en[0]`=1 and DEAD>0.
- `frame_start` is high for the single output cycle that reflects `tick`=0, `idx`=0. The first one follows reset release by one cycle.
- `busy` rises the cycle after the `load` edge. It falls the cycle after the boundary edge.
- The new shadow becomes visible in the first output cycle of the next frame.
- No select line is ever low for two digits in the same cycle.
- With DEAD>0, all selects are high for at least DEAD cycles between any two different digits.

## Configuration
- `SEG_PWM_EN` defined:
  - Adds a 4-bit free-running counter `pwm` that increments every clk and is reset to 0.
  - A digit is lit only when `pwm` <= `bright`, in addition to the other conditions.
  - `bright`=15 gives full on; `bright`=0 gives a 1/16 duty.
- Not defined: the `bright` port and `pwm` counter are absent, and digits are lit for the whole non-dead part of the slot.

## Test plan
All scenarios use DIGITS=4, DIV=8, DEAD=2.
- Reset then idle, shadow=0, `digit_en`=0 → `seg_sel_n`=4'hF and `seg`=8'hFF throughout. `frame_start` pulses every 32 cycles, first at output cycle 1.
- `load` `data`=16'h3A50, `dp`=4'b0010, `digit_en`=4'hF at cycle 3 → `busy` high until frame end. Next frame shows:
  - digit0 `seg`=C0, out cycles 3-8 of the slot window, `seg_sel_n`=4'b1110;
  - digit1 `seg`=12 (dp lit);
  - digit2 `seg`=88;
  - digit3 `seg`=B0.
- Two `load`s in one frame (`data` 16'h1111, then 16'h2222) → only 2222 is displayed, and a single `busy` period covers both.
- `load` exactly on the boundary cycle → new data visible in the first frame after, and `busy` never rises.
- `digit_en`=4'b0101 → slots 1 and 3 are fully blank. Every cycle has at most one select low, with at least 2 all-high cycles between lit digits.
- `SEG_PWM_EN`, `bright`=3 → over the non-dead window, the lit fraction is 4/16 of cycles. Reset asserted mid-frame blanks the outputs on the next cycle.
